// File: rtl/aes_pkg.sv
// AES shared definitions: block type, S-box tables, Rcon, GF(2^8) and word helpers.
package aes_pkg;

    localparam int unsigned NB = 4;

    // 128-bit block viewed as 16 bytes; element 0 is bits [127:120]
    typedef logic [0:15][7:0] blk_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    // Rcon[j] for j = 1..10; entry 0 unused
    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[x];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] j);
        return (j <= 4'd10) ? RCON[j] : 8'h00;
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Combinational FIPS-197 key expansion; round key r occupies rk[128*r +: 128].
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic [32*NK-1:0]       key,
    output logic [128*(NK+7)-1:0]  rk
);

    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);

    // One word per generate block so each word depends only on earlier ones
    for (genvar i = 0; i < NW; i++) begin : g_w
        logic [31:0] w;
        if (i < NK) begin : g_key
            assign w = key[32*NK-1-32*i -: 32];
        end else begin : g_exp
            logic [31:0] t;
            if (i % NK == 0) begin : g_rot
                assign t = sub_word(rot_word(g_w[i-1].w)) ^ {rcon(4'(i / NK)), 24'h000000};
            end else if (NK > 6 && i % NK == 4) begin : g_sub
                assign t = sub_word(g_w[i-1].w);
            end else begin : g_pass
                assign t = g_w[i-1].w;
            end
            assign w = g_w[i-NK].w ^ t;
        end
        assign rk[128*(i/4) + 32*(3 - i%4) +: 32] = w;
    end

endmodule

// File: rtl/aes_cipher.sv
// Iterative AES encrypt/decrypt core, one round per clock, NK selects AES-128/192/256.
module aes_cipher
    import aes_pkg::*;
#(
    parameter int unsigned NK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         decrypt,
    input  logic [255:0] key,
    input  logic [127:0] data_in,
    output logic [127:0] data_out,
    output logic         busy,
    output logic         done
);

    localparam int unsigned NR = NK + 6;
    localparam int unsigned KW = 32 * NK;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]     st_q, st_d;
    blk_t           state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [KW-1:0]  key_q, key_d;
    logic           dec_q, dec_d;
    logic [127:0]   dout_d;
    logic           busy_d, done_d;

    logic           accept_c;
    logic [KW-1:0]  key_src_c;
    logic [NR:0][127:0] rk_all;
    logic [3:0]     ridx_c;
    logic [127:0]   rk_r_c;
    logic           last_c;
    blk_t           enc_c, dec_c, round_c;
    logic           key_unused;

    function automatic blk_t sub_bytes(input blk_t s, input logic inv);
        blk_t o;
        for (int n = 0; n < 16; n++) o[4'(n)] = inv ? inv_sbox(s[4'(n)]) : sbox(s[4'(n)]);
        return o;
    endfunction

    function automatic blk_t shift_rows(input blk_t s, input logic inv);
        blk_t o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[4'(4*c + r)] = inv ? s[4'(4*((c + 4 - r) % 4) + r)] : s[4'(4*((c + r) % 4) + r)];
            end
        end
        return o;
    endfunction

    function automatic blk_t mix_columns(input blk_t s, input logic inv);
        blk_t       o;
        logic [7:0] m [4];
        logic [7:0] acc;
        if (inv) begin
            m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(m[2'(k - r)], s[4'(4*c + k)]);
                o[4'(4*c + r)] = acc;
            end
        end
        return o;
    endfunction

    // The accepting cycle sees the incoming key so whitening needs no wait state
    assign accept_c   = start && (st_q == ST_IDLE);
    assign key_src_c  = accept_c ? key[255 -: KW] : key_q;
    assign key_unused = ^key;

    aes_key_expand #(.NK(NK)) u_key_expand (
        .key (key_src_c),
        .rk  (rk_all)
    );

    // One encrypt or decrypt round on the current state
    always_comb begin
        ridx_c  = dec_q ? (4'(NR) - cnt_q) : cnt_q;
        rk_r_c  = rk_all[ridx_c];
        last_c  = (cnt_q == 4'(NR));
        enc_c   = shift_rows(sub_bytes(state_q, 1'b0), 1'b0);
        if (!last_c) enc_c = mix_columns(enc_c, 1'b0);
        enc_c   = enc_c ^ rk_r_c;
        dec_c   = sub_bytes(shift_rows(state_q, 1'b1), 1'b1) ^ rk_r_c;
        if (!last_c) dec_c = mix_columns(dec_c, 1'b1);
        round_c = dec_q ? dec_c : enc_c;
    end

    // Next-state and output decode
    always_comb begin
        st_d    = st_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        key_d   = key_q;
        dec_d   = dec_q;
        dout_d  = data_out;
        busy_d  = busy;
        done_d  = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = data_in ^ (decrypt ? rk_all[NR] : rk_all[0]);
                    cnt_d   = 4'd1;
                    key_d   = key[255 -: KW];
                    dec_d   = decrypt;
                    busy_d  = 1'b1;
                    st_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = round_c;
                cnt_d   = cnt_q + 4'd1;
                if (last_c) begin
                    dout_d = round_c;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    cnt_d  = 4'd0;
                    st_d   = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q     <= ST_IDLE;
            state_q  <= '0;
            cnt_q    <= 4'd0;
            key_q    <= '0;
            dec_q    <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            st_q     <= st_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            dec_q    <= dec_d;
            data_out <= dout_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher at NK = 4, 6 and 8 using FIPS-197 known-answer vectors.
module tb_aes_cipher;

    typedef struct {
        int           dut;
        logic [127:0] data;
        int           start_cyc;
        int           lat;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         decrypt;
    logic [255:0] key;
    logic [127:0] data_in;
    logic         start [3];
    logic [127:0] dout  [3];
    logic         busy  [3];
    logic         done  [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int nr [3]   = '{10, 12, 14};

    exp_t         exp_q [$];
    exp_t         mon_e;
    logic [255:0] keys [3];
    logic [127:0] cts  [3];

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    aes_cipher #(.NK(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .decrypt(decrypt), .key(key),
        .data_in(data_in), .data_out(dout[0]), .busy(busy[0]), .done(done[0])
    );
    aes_cipher #(.NK(6)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .decrypt(decrypt), .key(key),
        .data_in(data_in), .data_out(dout[1]), .busy(busy[1]), .done(done[1])
    );
    aes_cipher #(.NK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .decrypt(decrypt), .key(key),
        .data_in(data_in), .data_out(dout[2]), .busy(busy[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: dut=%0d data_out=%h", k, dout[k]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("done_dut", 128'(k), 128'(mon_e.dut));
                    chk($sformatf("data_out_dut%0d", k), dout[k], mon_e.data);
                    chk($sformatf("latency_dut%0d", k), 128'(cyc - mon_e.start_cyc), 128'(mon_e.lat));
                end
            end
        end
    end

    // Called at a falling edge: drive one start pulse and log the expected result
    task automatic issue(input int k, input logic dec, input logic [255:0] kk,
                         input logic [127:0] din, input logic [127:0] exp);
        exp_t e;
        key      = kk;
        data_in  = din;
        decrypt  = dec;
        start[k] = 1'b1;
        e.dut       = k;
        e.data      = exp;
        e.start_cyc = cyc;
        e.lat       = nr[k] + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start[k] = 1'b0;
        key      = ~kk;
        data_in  = ~din;
        decrypt  = ~dec;
        chk($sformatf("busy_after_start_dut%0d", k), 128'(busy[k]), 128'(1));
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: outstanding=%0d expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        keys[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'hdeadbeefcafef00d0123456789abcdef};
        keys[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'ha5a5a5a55a5a5a5a};
        keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        cts[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        cts[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        cts[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;

        rst_n   = 1'b0;
        decrypt = 1'b0;
        key     = '0;
        data_in = '0;
        for (int k = 0; k < 3; k++) start[k] = 1'b0;
        repeat (2) @(negedge clk);

        // Start coincident with reset must be ignored
        start[0] = 1'b1;
        key      = keys[0];
        data_in  = PT;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_data_out_dut%0d", k), dout[k], 128'h0);
            chk($sformatf("reset_busy_dut%0d", k), 128'(busy[k]), 128'(0));
            chk($sformatf("reset_done_dut%0d", k), 128'(done[k]), 128'(0));
        end
        start[0] = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("reset_priority_busy", 128'(busy[0]), 128'(0));

        // Known-answer encrypt and decrypt for each key size
        for (int k = 0; k < 3; k++) begin
            issue(k, 1'b0, keys[k], PT, cts[k]);
            wait_drain(40);
            issue(k, 1'b1, keys[k], cts[k], PT);
            wait_drain(40);
        end

        // Back-to-back start in the done cycle; data_out holds during the next block
        issue(0, 1'b0, keys[0], PT, cts[0]);
        repeat (nr[0]) @(negedge clk);
        chk("b2b_busy_low_at_done", 128'(busy[0]), 128'(0));
        issue(0, 1'b1, keys[0], cts[0], PT);
        repeat (3) @(negedge clk);
        chk("data_out_hold", dout[0], cts[0]);
        wait_drain(40);

        // Start while busy is ignored
        issue(0, 1'b0, keys[0], PT, cts[0]);
        repeat (4) @(negedge clk);
        start[0] = 1'b1;
        data_in  = 128'hffeeddccbbaa99887766554433221100;
        key      = keys[2];
        decrypt  = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_drain(40);
        repeat (20) @(negedge clk);

        // Reset mid-operation aborts without a done pulse
        issue(0, 1'b0, keys[0], PT, cts[0]);
        repeat (5) @(negedge clk);
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 128'(busy[0]), 128'(0));
        chk("abort_done", 128'(done[0]), 128'(0));
        chk("abort_data_out", dout[0], 128'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        issue(0, 1'b0, keys[0], PT, cts[0]);
        wait_drain(40);
        issue(2, 1'b1, keys[2], cts[2], PT);
        wait_drain(40);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
